// File: rtl/gcd_req_arbiter.sv
// Round-robin front end for a single shared GCD engine.
// Accepts one request at a time and latches its operands. Operand pairs
// containing a zero skip the engine. A hung engine is cut off by a timeout.
// Every accepted request produces one tagged response.
module gcd_req_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 5,
  parameter  int TIMEOUT = 15,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_a,
  output logic [WIDTH-1:0]         eng_b,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_result,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     win_q;
  logic [7:0]         cnt_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               eng_start_q;
  logic [WIDTH-1:0]   eng_a_q;
  logic [WIDTH-1:0]   eng_b_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic               busy_q;

  logic [IDW-1:0]     win_d;
  logic [WIDTH-1:0]   a_sel_d;
  logic [WIDTH-1:0]   b_sel_d;
  logic [IDW-1:0]     ptr_d;
  int                 idx_c;

  // Round-robin winner search starting at ptr_q. The scan runs from the
  // farthest slot back to ptr_q, so the last match kept is the nearest one.
  always_comb begin
    win_d   = '0;
    a_sel_d = '0;
    b_sel_d = '0;
    idx_c   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_c = (int'(ptr_q) + i) % NUM_REQ;
      if (req[idx_c]) begin
        win_d   = IDW'(idx_c);
        a_sel_d = req_a[idx_c*WIDTH +: WIDTH];
        b_sel_d = req_b[idx_c*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves to the slot just after the requester being served.
  always_comb begin
    ptr_d = (win_q == IDW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  end

  // Sequencer FSM. All outputs are set on the edge that enters the state
  // in which they must be visible, so every output comes from a flop.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      gnt_q       <= '0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req != '0) begin
            win_q   <= win_d;
            op_a_q  <= a_sel_d;
            op_b_q  <= b_sel_d;
            gnt_q   <= NUM_REQ'(1) << win_d;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
            // The launch pulse shares the cycle with the grant.
            if (a_sel_d != '0 && b_sel_d != '0) begin
              eng_start_q <= 1'b1;
              eng_a_q     <= a_sel_d;
              eng_b_q     <= b_sel_d;
            end
          end
        end
        LAUNCH: begin
          if (op_a_q != '0 && op_b_q != '0) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            // gcd(0,x) = x. A zero-zero pair falls through to 0.
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_q;
            rsp_data_q  <= (op_a_q == '0) ? op_b_q : op_a_q;
            rsp_err_q   <= 1'b0;
            state_q     <= RESPOND;
          end
        end
        WAIT: begin
          if (eng_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_q;
            rsp_data_q  <= eng_result;
            rsp_err_q   <= 1'b0;
            state_q     <= RESPOND;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_q;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RESPOND;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESPOND: begin
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign eng_start = eng_start_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Bench for gcd_req_arbiter.
// Directed requests push their expected grant and response into queues.
// A monitor pops the queues and compares whenever the DUT presents them.
module tb_gcd_req_arbiter;
  localparam int N   = 4;
  localparam int W   = 5;
  localparam int TO  = 15;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           Reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   gnt;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_result = '0;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  gcd_req_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int data;
    int err;
  } rsp_t;

  rsp_t sbq[$];
  int   gq[$];
  int   total = 0;
  int   bad = 0;
  int   eng_delay = 1;
  bit   eng_hang = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gcd_f(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Engine model: answers with the true GCD eng_delay cycles after launch.
  initial begin
    int ra, rb;
    forever begin
      @(negedge CLK);
      if (eng_start === 1'b1 && !eng_hang) begin
        ra = int'(eng_a);
        rb = int'(eng_b);
        repeat (eng_delay) @(negedge CLK);
        eng_result = W'(gcd_f(ra, rb));
        eng_done   = 1'b1;
        @(negedge CLK);
        eng_done   = 1'b0;
      end
    end
  end

  // Monitor: grants and responses compared against the queued expectations.
  initial begin
    rsp_t e;
    forever begin
      @(negedge CLK);
      if (gnt != '0) begin
        check("gnt_onehot", $countones(gnt), 1);
        if (gq.size() == 0) check("gnt_unexpected", int'(gnt), 0);
        else check("gnt_vec", int'(gnt), gq.pop_front());
      end
      if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("rsp_id", int'(rsp_id), e.id);
          check("rsp_data", int'(rsp_data), e.data);
          check("rsp_err", int'(rsp_err), e.err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string name);
    check(name, int'({gnt, eng_start, eng_a, eng_b, rsp_valid, rsp_id,
                      rsp_data, rsp_err, busy}), 0);
  endtask

  // Issue one request, expect its grant, optionally wait for its response.
  task automatic issue(input int id, input int a, input int b,
                       input int exp_data, input int exp_err,
                       input int exp_start, input int wait_rsp,
                       output int lat);
    rsp_t e;
    bit got;
    e.id = id; e.data = exp_data; e.err = exp_err;
    gq.push_back(1 << id);
    if (wait_rsp != 0) sbq.push_back(e);
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
    req[id] = 1'b1;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (gnt != '0) got = 1'b1;
    end
    check("gnt_seen", int'(got), 1);
    check("eng_start_at_gnt", int'(eng_start), exp_start);
    if (exp_start != 0) begin
      check("eng_a", int'(eng_a), a);
      check("eng_b", int'(eng_b), b);
    end
    req[id] = 1'b0;
    if (wait_rsp != 0) begin
      got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
        @(negedge CLK);
        if (rsp_valid === 1'b1) begin
          got = 1'b1;
          lat = k;
        end
      end
      check("rsp_seen", int'(got), 1);
      @(negedge CLK);
      check("busy_after_rsp", int'(busy), 0);
    end
  endtask

  initial begin
    int lat, cnt;
    // Reset state
    repeat (2) @(negedge CLK);
    check_all_zero("reset_outputs");
    Reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Single request through the engine
    eng_delay = 3;
    issue(0, 12, 18, 6, 0, 1, 1, lat);
    check("lat_single", lat, 4);

    // Fairness from a fresh pointer
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    eng_delay = 1;
    req_a = {W'(7), W'(10), W'(9), W'(12)};
    req_b = {W'(21), W'(15), W'(6), W'(18)};
    gq.push_back(1); gq.push_back(2); gq.push_back(4); gq.push_back(8); gq.push_back(1);
    sbq.push_back('{0, 6, 0}); sbq.push_back('{1, 3, 0}); sbq.push_back('{2, 5, 0});
    sbq.push_back('{3, 7, 0}); sbq.push_back('{0, 6, 0});
    req = '1;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 5; k++) begin
      @(negedge CLK);
      if (gnt != '0) cnt++;
    end
    req = '0;
    check("fair_grants", cnt, 5);
    repeat (8) @(negedge CLK);

    // Zero bypass
    issue(2, 0, 21, 21, 0, 0, 1, lat);
    check("lat_bypass", lat, 1);
    issue(2, 0, 0, 0, 0, 0, 1, lat);
    check("lat_bypass_zero", lat, 1);

    // Timeout, then normal service
    eng_hang = 1'b1;
    issue(3, 5, 10, 0, 1, 1, 1, lat);
    check("lat_timeout", lat, 16);
    eng_hang = 1'b0;
    eng_delay = 2;
    issue(3, 5, 10, 5, 0, 1, 1, lat);
    check("lat_after_timeout", lat, 3);

    // Done on the last WAIT cycle beats the timeout
    eng_delay = 15;
    issue(1, 14, 21, 7, 0, 1, 1, lat);
    check("lat_coincide", lat, 16);

    // Reset while waiting: no response, late done ignored
    eng_delay = 6;
    issue(2, 8, 12, 0, 0, 1, 0, lat);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check_all_zero("reset_in_wait");
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    repeat (8) @(negedge CLK);
    check("busy_after_abort", int'(busy), 0);
    eng_delay = 1;
    issue(1, 4, 6, 2, 0, 1, 1, lat);
    check("lat_after_abort", lat, 2);

    repeat (3) @(negedge CLK);
    check("sb_left", sbq.size(), 0);
    check("gq_left", gq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
